// File: rtl/avr_dmem_pkg.sv
// avr_dmem_pkg
// Shared definitions for the AVR data-memory path: default RAM geometry
// (also used by data_memory) and the read-return source encoding used by
// avr_dmem_arbiter.
package avr_dmem_pkg;

    localparam int DMEM_ADDR_W = 11;
    localparam int DMEM_DATA_W = 8;

    // Width of the starvation counter; STARVE_LIMIT must fit (1..15).
    localparam int STARVE_CNT_W = 4;

    // Source of the read whose data arrives on mem_rdata this cycle.
    typedef enum logic [1:0] {
        RD_NONE    = 2'd0,
        RD_CPU     = 2'd1,
        RD_CPU_OOB = 2'd2,
        RD_EXT     = 2'd3
    } rd_src_t;

endpackage : avr_dmem_pkg

// File: rtl/avr_dmem_starve_ctr.sv
// avr_dmem_starve_ctr
// Saturating counter of consecutive cycles the external master was denied.
// Ports:
//   CLK       clock
//   RST       synchronous active-high reset (count -> 0)
//   inc_i     ext requested but was not granted
//   clr_i     ext granted or not requesting
//   freeze_i  hold the count (bus lock active)
//   at_limit_o count has reached LIMIT
module avr_dmem_starve_ctr
    import avr_dmem_pkg::*;
#(
    parameter int LIMIT = 4
) (
    input  logic CLK,
    input  logic RST,
    input  logic inc_i,
    input  logic clr_i,
    input  logic freeze_i,
    output logic at_limit_o
);

    localparam logic [STARVE_CNT_W-1:0] LIMIT_C = STARVE_CNT_W'(LIMIT);

    logic [STARVE_CNT_W-1:0] cnt_q;
    logic [STARVE_CNT_W-1:0] cnt_d;

    // Next count: freeze beats clear, clear beats increment; saturate at LIMIT.
    always_comb begin
        cnt_d = cnt_q;
        if (freeze_i) begin
            cnt_d = cnt_q;
        end else if (clr_i) begin
            cnt_d = {STARVE_CNT_W{1'b0}};
        end else if (inc_i && (cnt_q != LIMIT_C)) begin
            cnt_d = cnt_q + {{(STARVE_CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q <= {STARVE_CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_limit_o = (cnt_q == LIMIT_C);

endmodule : avr_dmem_starve_ctr

// File: rtl/avr_dmem_arbiter.sv
// avr_dmem_arbiter
// Shares the single-port AVR data RAM between the CPU data port and one
// external (debug/DMA) master. CPU has priority; the external master is
// forced through after STARVE_LIMIT consecutive denied cycles.
// Optional feature macro: AVR_DMEM_ARB_LOCK_EN (adds ext_lock bus locking).
// Ports:
//   CLK, RST                        clock, synchronous active-high reset
//   cpu_req/we/addr/wdata           CPU access request (16-bit address)
//   cpu_rdata                       CPU read data, cycle after granted read
//   cpu_stall                       CPU lost arbitration, must retry
//   ext_req/we/addr/wdata           external master request
//   ext_lock (macro only)           keep ownership across grants
//   ext_gnt                         external access accepted this cycle
//   ext_rvalid/ext_rdata            external read return
//   cpu_oob                         sticky: CPU accessed beyond the RAM
//   mem_addr/we/wdata, mem_rdata    RAM port (1-cycle registered read)
module avr_dmem_arbiter
    import avr_dmem_pkg::*;
#(
    parameter int ADDR_W       = DMEM_ADDR_W,
    parameter int DATA_W       = DMEM_DATA_W,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [15:0]       cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              ext_req,
    input  logic              ext_we,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [DATA_W-1:0] ext_wdata,
`ifdef AVR_DMEM_ARB_LOCK_EN
    input  logic              ext_lock,
`endif
    output logic              ext_gnt,
    output logic              ext_rvalid,
    output logic [DATA_W-1:0] ext_rdata,
    output logic              cpu_oob,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    logic              cpu_win_s;
    logic              ext_win_s;
    logic              oob_addr_s;
    logic              at_limit_s;
    logic              lock_q;
    logic              lock_d;
    rd_src_t           rd_src_q;
    rd_src_t           rd_src_d;
    logic              cpu_oob_q;
    logic              cpu_oob_d;
    logic [ADDR_W-1:0] mem_addr_q;

    assign oob_addr_s = |cpu_addr[15:ADDR_W];

    // Arbitration: nothing is granted while in reset; a held lock gives ext
    // the bus outright; otherwise CPU wins contention unless ext is starved.
    always_comb begin
        cpu_win_s = 1'b0;
        ext_win_s = 1'b0;
        if (RST) begin
            cpu_win_s = 1'b0;
            ext_win_s = 1'b0;
        end else if (lock_q) begin
            cpu_win_s = 1'b0;
            ext_win_s = ext_req;
        end else if (cpu_req && ext_req) begin
            cpu_win_s = ~at_limit_s;
            ext_win_s = at_limit_s;
        end else begin
            cpu_win_s = cpu_req;
            ext_win_s = ext_req;
        end
    end

    // RAM port mux; out-of-range CPU writes are suppressed, and an idle
    // cycle keeps the previous address on the bus.
    always_comb begin
        mem_addr  = mem_addr_q;
        mem_we    = 1'b0;
        mem_wdata = {DATA_W{1'b0}};
        if (cpu_win_s) begin
            mem_addr  = cpu_addr[ADDR_W-1:0];
            mem_we    = cpu_we & ~oob_addr_s;
            mem_wdata = cpu_wdata;
        end else if (ext_win_s) begin
            mem_addr  = ext_addr;
            mem_we    = ext_we;
            mem_wdata = ext_wdata;
        end else begin
            mem_addr  = mem_addr_q;
            mem_we    = 1'b0;
            mem_wdata = {DATA_W{1'b0}};
        end
    end

    // Record who owns the data returning next cycle, the sticky OOB flag and
    // the next lock state.
    always_comb begin
        rd_src_d  = RD_NONE;
        cpu_oob_d = cpu_oob_q | (cpu_win_s & oob_addr_s);
        lock_d    = lock_q;
        if (cpu_win_s && !cpu_we) begin
            rd_src_d = oob_addr_s ? RD_CPU_OOB : RD_CPU;
        end else if (ext_win_s && !ext_we) begin
            rd_src_d = RD_EXT;
        end else begin
            rd_src_d = RD_NONE;
        end
`ifdef AVR_DMEM_ARB_LOCK_EN
        if (ext_win_s) begin
            lock_d = ext_lock;
        end else if (!ext_req) begin
            lock_d = 1'b0;
        end else begin
            lock_d = lock_q;
        end
`else
        lock_d = 1'b0;
`endif
    end

    // State registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_src_q   <= RD_NONE;
            cpu_oob_q  <= 1'b0;
            lock_q     <= 1'b0;
            mem_addr_q <= {ADDR_W{1'b0}};
        end else begin
            rd_src_q   <= rd_src_d;
            cpu_oob_q  <= cpu_oob_d;
            lock_q     <= lock_d;
            mem_addr_q <= mem_addr;
        end
    end

    avr_dmem_starve_ctr #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .CLK        (CLK),
        .RST        (RST),
        .inc_i      (ext_req & ~ext_win_s),
        .clr_i      (ext_win_s | ~ext_req),
        .freeze_i   (lock_q),
        .at_limit_o (at_limit_s)
    );

    // Read returns are masked during reset so a pending read is dropped.
    assign cpu_stall  = cpu_req & ~cpu_win_s & ~RST;
    assign ext_gnt    = ext_win_s;
    assign ext_rvalid = ~RST & (rd_src_q == RD_EXT);
    assign ext_rdata  = ext_rvalid ? mem_rdata : {DATA_W{1'b0}};
    assign cpu_rdata  = (~RST & (rd_src_q == RD_CPU)) ? mem_rdata : {DATA_W{1'b0}};
    assign cpu_oob    = cpu_oob_q;

endmodule : avr_dmem_arbiter

// File: tb/tb_avr_dmem_arbiter.sv
// Self-checking bench for avr_dmem_arbiter: directed stimulus, read returns
// checked by a scoreboard monitor, combinational grant/stall/mux outputs
// checked inline. Build with AVR_DMEM_ARB_LOCK_EN to cover bus locking.
module tb_avr_dmem_arbiter;

    localparam int ADDR_W = 11;
    localparam int DATA_W = 8;

    logic              CLK;
    logic              RST;
    logic              cpu_req;
    logic              cpu_we;
    logic [15:0]       cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_stall;
    logic              ext_req;
    logic              ext_we;
    logic [ADDR_W-1:0] ext_addr;
    logic [DATA_W-1:0] ext_wdata;
    logic              ext_lock;
    logic              ext_gnt;
    logic              ext_rvalid;
    logic [DATA_W-1:0] ext_rdata;
    logic              cpu_oob;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    avr_dmem_arbiter #(
        .ADDR_W       (ADDR_W),
        .DATA_W       (DATA_W),
        .STARVE_LIMIT (4)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_stall  (cpu_stall),
        .ext_req    (ext_req),
        .ext_we     (ext_we),
        .ext_addr   (ext_addr),
        .ext_wdata  (ext_wdata),
`ifdef AVR_DMEM_ARB_LOCK_EN
        .ext_lock   (ext_lock),
`endif
        .ext_gnt    (ext_gnt),
        .ext_rvalid (ext_rvalid),
        .ext_rdata  (ext_rdata),
        .cpu_oob    (cpu_oob),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // RAM model: registered read, preloaded while reset is held.
    logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];
    always @(posedge CLK) begin
        if (RST) begin
            ram[16]  <= 8'hA5;
            ram[256] <= 8'h77;
        end else if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
        end
        mem_rdata <= ram[mem_addr];
    end

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int              cyc;
        logic [7:0]      data;
    } exp_t;

    exp_t       cpu_q[$];
    logic [7:0] ext_q[$];
    exp_t       mon_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: CPU returns are due on a known cycle, ext returns
    // whenever ext_rvalid is presented.
    always @(negedge CLK) begin
        if (cpu_q.size() > 0 && cpu_q[0].cyc == cyc) begin
            mon_e = cpu_q.pop_front();
            chk("cpu_rdata", {24'd0, cpu_rdata}, {24'd0, mon_e.data});
        end
        if (ext_rvalid === 1'b1) begin
            if (ext_q.size() == 0) begin
                chk("ext_rvalid_unexpected", 32'd1, 32'd0);
            end else begin
                chk("ext_rdata", {24'd0, ext_rdata}, {24'd0, ext_q.pop_front()});
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        cpu_req  = 1'b0;
        cpu_we   = 1'b0;
        ext_req  = 1'b0;
        ext_we   = 1'b0;
        ext_lock = 1'b0;
    endtask

    task automatic set_cpu(input logic we, input logic [15:0] a, input logic [7:0] d);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    endtask

    task automatic set_ext(input logic we, input logic [10:0] a, input logic [7:0] d);
        ext_req = 1'b1; ext_we = we; ext_addr = a; ext_wdata = d;
    endtask

    task automatic push_cpu(input logic [7:0] d);
        exp_t e;
        e.cyc  = cyc + 1;
        e.data = d;
        cpu_q.push_back(e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1;
        cpu_addr = 16'h0000; cpu_wdata = 8'h00;
        ext_addr = 11'h000;  ext_wdata = 8'h00;
        idle();
        // Reset: requests present but nothing may be granted or stalled.
        cpu_req = 1'b1; cpu_we = 1'b1; ext_req = 1'b1; ext_we = 1'b1;
        tick();
        @(negedge CLK);
        chk("rst_cpu_stall", {31'd0, cpu_stall}, 32'd0);
        chk("rst_ext_gnt", {31'd0, ext_gnt}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_ext_rvalid", {31'd0, ext_rvalid}, 32'd0);
        chk("rst_cpu_rdata", {24'd0, cpu_rdata}, 32'd0);
        chk("rst_ext_rdata", {24'd0, ext_rdata}, 32'd0);
        chk("rst_cpu_oob", {31'd0, cpu_oob}, 32'd0);
        tick();
        RST = 1'b0;
        idle();
        tick();

        // 1: CPU-only read of 0x0010.
        set_cpu(1'b0, 16'h0010, 8'h00);
        push_cpu(8'hA5);
        @(negedge CLK);
        chk("t1_mem_addr", {21'd0, mem_addr}, 32'h010);
        chk("t1_cpu_stall", {31'd0, cpu_stall}, 32'd0);
        chk("t1_mem_we", {31'd0, mem_we}, 32'd0);
        tick();
        idle();
        tick();

        // 2: ext write 0x3C to 0x7FF, then read it back.
        set_ext(1'b1, 11'h7FF, 8'h3C);
        @(negedge CLK);
        chk("t2_ext_gnt_w", {31'd0, ext_gnt}, 32'd1);
        chk("t2_mem_we", {31'd0, mem_we}, 32'd1);
        chk("t2_mem_addr", {21'd0, mem_addr}, 32'h7FF);
        chk("t2_mem_wdata", {24'd0, mem_wdata}, 32'h3C);
        tick();
        set_ext(1'b0, 11'h7FF, 8'h00);
        ext_q.push_back(8'h3C);
        @(negedge CLK);
        chk("t2_ext_gnt_r", {31'd0, ext_gnt}, 32'd1);
        tick();
        idle();
        tick();

        // 3: continuous contention -> 4 CPU grants : 1 ext grant.
        set_cpu(1'b0, 16'h0010, 8'h00);
        set_ext(1'b0, 11'h7FF, 8'h00);
        for (int k = 0; k < 10; k++) begin
            if (k % 5 == 4) ext_q.push_back(8'h3C);
            else            push_cpu(8'hA5);
            @(negedge CLK);
            chk("t3_ext_gnt", {31'd0, ext_gnt}, (k % 5 == 4) ? 32'd1 : 32'd0);
            chk("t3_cpu_stall", {31'd0, cpu_stall}, (k % 5 == 4) ? 32'd1 : 32'd0);
            chk("t3_mem_addr", {21'd0, mem_addr}, (k % 5 == 4) ? 32'h7FF : 32'h010);
            tick();
        end
        idle();
        tick();

        // 4: CPU out-of-range write is blocked and flagged; OOB read returns 0.
        chk("t4_oob_before", {31'd0, cpu_oob}, 32'd0);
        set_cpu(1'b1, 16'h0900, 8'h55);
        @(negedge CLK);
        chk("t4_mem_we", {31'd0, mem_we}, 32'd0);
        chk("t4_cpu_stall", {31'd0, cpu_stall}, 32'd0);
        tick();
        idle();
        @(negedge CLK);
        chk("t4_oob_set", {31'd0, cpu_oob}, 32'd1);
        tick(); tick(); tick();
        @(negedge CLK);
        chk("t4_oob_sticky", {31'd0, cpu_oob}, 32'd1);
        set_cpu(1'b0, 16'h0900, 8'h00);
        push_cpu(8'h00);
        tick();
        set_cpu(1'b0, 16'h0100, 8'h00);
        push_cpu(8'h77);
        tick();
        idle();
        tick();

        // 5a: reset clears a partly built starvation count.
        set_cpu(1'b1, 16'h0030, 8'h11);
        set_ext(1'b1, 11'h031, 8'h22);
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            chk("t5a_pre_ext_gnt", {31'd0, ext_gnt}, 32'd0);
            tick();
        end
        RST = 1'b1;
        @(negedge CLK);
        chk("t5a_rst_ext_gnt", {31'd0, ext_gnt}, 32'd0);
        chk("t5a_rst_cpu_stall", {31'd0, cpu_stall}, 32'd0);
        tick();
        RST = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge CLK);
            chk("t5a_post_ext_gnt", {31'd0, ext_gnt}, (k == 4) ? 32'd1 : 32'd0);
            tick();
        end
        chk("t5a_oob_cleared", {31'd0, cpu_oob}, 32'd0);
        idle();
        tick();

        // 5b: reset right after a granted ext read drops the return.
        set_ext(1'b0, 11'h7FF, 8'h00);
        @(negedge CLK);
        chk("t5b_ext_gnt", {31'd0, ext_gnt}, 32'd1);
        tick();
        RST = 1'b1;
        idle();
        @(negedge CLK);
        chk("t5b_rvalid_in_rst", {31'd0, ext_rvalid}, 32'd0);
        tick();
        RST = 1'b0;
        @(negedge CLK);
        chk("t5b_rvalid_after", {31'd0, ext_rvalid}, 32'd0);
        chk("t5b_oob", {31'd0, cpu_oob}, 32'd0);
        tick();

`ifdef AVR_DMEM_ARB_LOCK_EN
        // 6: locked ext owns the bus for 6 grants; CPU wins after unlock.
        for (int g = 0; g < 7; g++) begin
            set_ext(1'b1, 11'h040, 8'(g));
            ext_lock = (g < 6);
            if (g >= 1) set_cpu(1'b1, 16'h0020, 8'h99);
            @(negedge CLK);
            chk("t6_ext_gnt", {31'd0, ext_gnt}, 32'd1);
            chk("t6_cpu_stall", {31'd0, cpu_stall}, (g >= 1) ? 32'd1 : 32'd0);
            tick();
        end
        @(negedge CLK);
        chk("t6_unlock_ext_gnt", {31'd0, ext_gnt}, 32'd0);
        chk("t6_unlock_cpu_stall", {31'd0, cpu_stall}, 32'd0);
        tick();
        idle();
        tick();
`endif

        tick();
        tick();
        chk("cpu_q_drained", cpu_q.size(), 32'd0);
        chk("ext_q_drained", ext_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_avr_dmem_arbiter

// File: doc/avr_dmem_arbiter.md
Name: avr_dmem_arbiter

Overview:
Shares the single-port AVR data RAM between the CPU data port and one external master (debug/DMA). The CPU has priority, and the external master is guaranteed service by a starvation counter. The block drives the CPU stall input whenever a CPU access loses arbitration. It sits between avr_cpu, the debug/DMA master and data_memory; the top level owns the RAM's bidirectional data bus, and this block uses split read/write data.

Parameters:
ADDR_W, 11, RAM address width; RAM holds 2**ADDR_W bytes
DATA_W, 8, data width
STARVE_LIMIT, 4, consecutive denied ext cycles before ext is forced to win; range 1..15

Ports:
CLK  in  1  clock, single domain
RST  in  1  reset, synchronous, active-high
cpu_req  in  1  CPU access request this cycle
cpu_we  in  1  CPU write (1) / read (0)
cpu_addr  in  16  CPU data address
cpu_wdata  in  DATA_W  CPU write data
cpu_rdata  out  DATA_W  CPU read data, valid the cycle after a granted read
cpu_stall  out  1  CPU must hold its request and retry
ext_req  in  1  external request
ext_we  in  1  external write/read
ext_addr  in  ADDR_W  external address
ext_wdata  in  DATA_W  external write data
ext_gnt  out  1  external access accepted this cycle
ext_rvalid  out  1  ext_rdata valid, one cycle after a granted read
ext_rdata  out  DATA_W  external read data
cpu_oob  out  1  sticky flag: CPU accessed an address at or above 2**ADDR_W
mem_addr  out  ADDR_W  RAM address
mem_we  out  1  RAM write enable
mem_wdata  out  DATA_W  RAM write data
mem_rdata  in  DATA_W  RAM read data, registered, 1-cycle latency

Behaviour:
- Grant is combinational from the current requests plus registered state. At most one requester is granted per cycle, and mem_* follow the winner.
- Arbitration:
  - Only one requester active: that requester wins.
  - Both active: CPU wins unless starve_cnt == STARVE_LIMIT, in which case ext wins.
  - Neither active: mem_we = 0, mem_addr holds its last value.
- starve_cnt (registered):
  - Increments when ext_req = 1 and ext is not granted, saturating at STARVE_LIMIT.
  - Clears to 0 on an ext grant, or when ext_req = 0.
- Stall and grant outputs:
  - cpu_stall = cpu_req and not CPU-granted (combinational).
  - ext_gnt = ext granted.
  - Denied requesters hold their request; no state is kept for a denied request.
- CPU out-of-range access (cpu_addr[15:ADDR_W] != 0):
  - Still arbitrated, but mem_we is forced to 0.
  - cpu_rdata returns 0 the next cycle.
  - cpu_oob sets; it clears only on RST.
- Read return:
  - Register rd_src (NONE/CPU/CPU_OOB/EXT) records the source of the granted read.
  - Next cycle: cpu_rdata = mem_rdata if rd_src = CPU, 0 otherwise.
  - ext_rvalid = (rd_src == EXT) and ext_rdata = mem_rdata.
  - Writes set rd_src = NONE.
- Back-to-back grants are permitted with no dead cycle between owners. A read's data returns in the same cycle as the next owner's address phase.
- Reset (RST sampled high at posedge):
  - starve_cnt = 0, rd_src = NONE, cpu_oob = 0.
  - ext_rvalid = 0, cpu_rdata = 0, ext_rdata = 0.
  - While RST is high: mem_we = 0, ext_gnt = 0, cpu_stall = 0.
  - Reset mid-read drops the pending return; no ext_rvalid follows reset.

Optional Feature:
AVR_DMEM_ARB_LOCK_EN
- Enabled: adds input ext_lock (1 bit).
  - If ext is granted with ext_lock = 1, a registered lock bit sets.
  - While the lock bit is set, ext wins every cycle it requests, CPU stalls on any request, and starve_cnt is frozen.
  - The lock clears on the first ext grant with ext_lock = 0, when ext_req drops, or on RST.
- Disabled: no ext_lock port; arbitration exactly as above.

Decomposition:
- Package avr_dmem_pkg: rd_src_t enum (NONE, CPU, CPU_OOB, EXT), and defaults DMEM_ADDR_W = 11 and DMEM_DATA_W = 8, shared with data_memory.
- One natural sub-module, avr_dmem_starve_ctr: the saturating counter with inc/clr/freeze inputs and an at_limit output.
- Mux and return logic stay in the top module.

Test Plan:
1. CPU-only read: cpu_req = 1, we = 0, addr = 0x0010, RAM[0x10] = 0xA5 -> mem_addr = 0x010 the same cycle, cpu_stall = 0, cpu_rdata = 0xA5 next cycle.
2. Ext-only write then read: write 0x3C to 0x7FF -> ext_gnt = 1, mem_we = 1. Read 0x7FF -> ext_rvalid = 1 one cycle later with ext_rdata = 0x3C.
3. Contention, STARVE_LIMIT = 4: both requesting continuously -> CPU granted 4 cycles, ext granted in the 5th with cpu_stall = 1 that cycle, then pattern repeats (4 CPU : 1 ext).
4. CPU out-of-range: write 0x55 to 0x0900 -> mem_we = 0, cpu_oob = 1, stays 1. Read 0x0900 -> cpu_rdata = 0 next cycle.
5. Reset mid-read: ext read granted, RST high the next posedge -> ext_rvalid stays 0, starve_cnt = 0, cpu_oob = 0.
6. (LOCK_EN) ext_lock = 1 for 6 grants while CPU requests -> ext_gnt for 6 cycles, cpu_stall = 1 throughout. ext_lock = 0 on the 7th grant -> CPU wins the following cycle.
